ball_param_sched: RTL and testbench

- Once per frame, converts the float parameters of every ball (radius, posX, posY, posZ) into integer pixel parameters, using one shared FPmult and one shared fp2int.
- Replaces the four multiplier/converter pairs each ball renderer would otherwise need.
- Float inputs come from the physics parameter RAM. Results are double-buffered so the pixel pipeline always reads one consistent frame.
- Sits between the physics RAM and the per-pixel ball hit-test logic.

---
 rtl/ball_param_sched.sv | 188 ++++++++++++++++++
 tb/tb_ball_param_sched.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ball_param_sched.sv
// Per-frame float->int conversion of ball parameters through one shared multiply/convert datapath.
// Optional BALL_PARAM_PRECLAMP_EN adds a per-ball clamped draw size committed alongside the active bank.
`ifdef BALL_PARAM_PRECLAMP_EN
module ball_size_clamp (
    input  logic [31:0] rad,
    input  logic [31:0] z,
    input  logic [31:0] shift,
    output logic [31:0] size
);
    logic signed [33:0] s;

    // Widened so the three-way sum cannot wrap before the clamp.
    assign s = $signed({{2{z[31]}}, z}) + 34'sd10 + $signed({{2{shift[31]}}, shift})
             + $signed({{2{rad[31]}}, rad});

    always_comb begin
        size = s[31:0];
        if (rad == 32'd0)        size = 32'd0;
        else if (s < 34'sd0)     size = 32'd1;
        else if (s > 34'sd80)    size = 32'd80;
    end
endmodule
`endif

module ball_param_sched #(
    parameter int NUM_BALLS = 8,
    parameter int AW        = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          frame_start,
    input  logic          clr_overrun,
    input  logic [31:0]   relative_shift_z,
    output logic          mem_rd_en,
    output logic [AW+1:0] mem_addr,
    input  logic [31:0]   mem_rd_data,
    input  logic [AW-1:0] rd_idx,
    output logic [31:0]   rd_rad,
    output logic [31:0]   rd_x,
    output logic [31:0]   rd_y,
    output logic [31:0]   rd_z,
    output logic [31:0]   rd_size,
    output logic          busy,
    output logic          done,
    output logic          overrun
);
    typedef enum logic [2:0] {IDLE, REQ, CAPT, CONV, COMMIT} state_t;
    typedef logic [3:0][31:0] ball_t;

    state_t                  state, state_nx;
    logic [AW-1:0]           ball, ball_nx;
    logic [1:0]              field, field_nx;
    logic [31:0]             operand, konst, conv_res;
    logic                    commit, wr_en, ball_last, rd_ok;
    ball_t [NUM_BALLS-1:0]   shadow, bank;

    // Truncating single-precision multiply; zero/denormal operands flush to signed zero.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic [24:0]       pt;
        logic signed [9:0] e;
        logic [22:0]       m;
        pt = 25'(({24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]}) >> 23);
        e  = $signed({2'b0, a[30:23]}) + $signed({2'b0, b[30:23]}) - 10'sd127;
        if (pt[24]) begin
            m = pt[23:1];
            e = e + 10'sd1;
        end else begin
            m = pt[22:0];
        end
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0 || e <= 10'sd0) return {a[31] ^ b[31], 31'd0};
        if (e >= 10'sd255) return {a[31] ^ b[31], 8'hFF, 23'd0};
        return {a[31] ^ b[31], e[7:0], m};
    endfunction

    // Truncates toward zero, saturates to the 32-bit signed range.
    function automatic logic [31:0] fp2int(input logic [31:0] f);
        logic [54:0] mag;
        logic [31:0] ip;
        if (f[30:23] < 8'd127) return 32'd0;
        if (f[30:23] >= 8'd158) return f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        mag = {31'd0, 1'b1, f[22:0]} << (f[30:23] - 8'd127);
        ip  = 32'(mag >> 23);
        return f[31] ? (~ip + 32'd1) : ip;
    endfunction

    assign conv_res  = fp2int(fp_mul(operand, konst));
    assign ball_last = ({{(32-AW){1'b0}}, ball} == 32'(NUM_BALLS - 1));
    assign mem_rd_en = (state == REQ);
    assign mem_addr  = {ball, field};
    assign busy      = (state != IDLE);

    always_comb begin
        state_nx = state;
        ball_nx  = ball;
        field_nx = field;
        commit   = 1'b0;
        wr_en    = 1'b0;
        case (state)
            IDLE: if (frame_start) begin
                state_nx = REQ;
                ball_nx  = '0;
                field_nx = 2'd0;
            end
            REQ:  state_nx = CAPT;
            CAPT: state_nx = CONV;
            CONV: begin
                wr_en = 1'b1;
                if (field != 2'd3) begin
                    field_nx = field + 2'd1;
                    state_nx = REQ;
                end else if (!ball_last) begin
                    ball_nx  = ball + AW'(1);
                    field_nx = 2'd0;
                    state_nx = REQ;
                end else begin
                    state_nx = COMMIT;
                end
            end
            COMMIT: begin
                commit   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= IDLE;
            ball    <= '0;
            field   <= 2'd0;
            operand <= 32'd0;
            konst   <= 32'd0;
            shadow  <= '0;
            bank    <= '0;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state <= state_nx;
            ball  <= ball_nx;
            field <= field_nx;
            done  <= commit;
            if (state == CAPT) begin
                operand <= mem_rd_data;
                case (field)
                    2'd0:    konst <= 32'h4120_0000;
                    2'd3:    konst <= 32'h4000_0000;
                    default: konst <= 32'h42C8_0000;
                endcase
            end
            if (wr_en) shadow[ball][field] <= conv_res;
            if (commit) bank <= shadow;
            // A start request while already scanning is dropped but remembered; set beats clear.
            if (frame_start && state != IDLE) overrun <= 1'b1;
            else if (clr_overrun)             overrun <= 1'b0;
        end
    end

    assign rd_ok  = ({{(32-AW){1'b0}}, rd_idx} < 32'(NUM_BALLS));
    assign rd_rad = rd_ok ? bank[rd_idx][0] : 32'd0;
    assign rd_x   = rd_ok ? bank[rd_idx][1] : 32'd0;
    assign rd_y   = rd_ok ? bank[rd_idx][2] : 32'd0;
    assign rd_z   = rd_ok ? bank[rd_idx][3] : 32'd0;

`ifdef BALL_PARAM_PRECLAMP_EN
    logic [NUM_BALLS-1:0][31:0] size_nx, size_q;

    for (genvar g = 0; g < NUM_BALLS; g++) begin : g_clamp
        ball_size_clamp u_clamp (
            .rad   (shadow[g][0]),
            .z     (shadow[g][3]),
            .shift (relative_shift_z),
            .size  (size_nx[g])
        );
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)    size_q <= '0;
        else if (commit) size_q <= size_nx;
    end

    assign rd_size = rd_ok ? size_q[rd_idx] : 32'd0;
`else
    logic unused_shift;
    assign unused_shift = ^relative_shift_z;
    assign rd_size      = 32'd0;
`endif
endmodule

// File: tb/tb_ball_param_sched.sv
// Directed bench for ball_param_sched with NUM_BALLS=2 and a one-cycle-latency RAM model.
module tb_ball_param_sched;
    localparam int NB = 2;
    localparam int AW = 1;

    logic          Clk, Reset_n, frame_start, clr_overrun;
    logic [31:0]   relative_shift_z, mem_rd_data;
    logic          mem_rd_en, busy, done, overrun;
    logic [AW+1:0] mem_addr;
    logic [AW-1:0] rd_idx;
    logic [31:0]   rd_rad, rd_x, rd_y, rd_z, rd_size;

    int            tests, fails;
    int            done_at, ndone, n_addr;
    logic [AW+1:0] addr_log [0:15];
    logic [31:0]   rad_log  [0:40];
    logic [31:0]   ram      [0:7];

    ball_param_sched #(.NUM_BALLS(NB), .AW(AW)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .clr_overrun(clr_overrun),
        .relative_shift_z(relative_shift_z), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data), .rd_idx(rd_idx), .rd_rad(rd_rad), .rd_x(rd_x), .rd_y(rd_y),
        .rd_z(rd_z), .rd_size(rd_size), .busy(busy), .done(done), .overrun(overrun)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) if (mem_rd_en) mem_rd_data <= ram[mem_addr];

    task automatic load_ram(input logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7);
        ram[0] = w0; ram[1] = w1; ram[2] = w2; ram[3] = w3;
        ram[4] = w4; ram[5] = w5; ram[6] = w6; ram[7] = w7;
    endtask

    // k counts edges after the edge that samples frame_start; optional injection in cycle k==inj.
    task automatic run_frame(input int inj, input logic ifs, input logic iclr);
        done_at = -1; ndone = 0; n_addr = 0;
        @(negedge Clk); frame_start = 1'b1;
        for (int k = 0; k <= 40; k++) begin
            @(posedge Clk); #1;
            frame_start = 1'b0; clr_overrun = 1'b0;
            if (done) begin ndone++; if (done_at < 0) done_at = k; end
            if (mem_rd_en && n_addr < 16) begin addr_log[n_addr] = mem_addr; n_addr++; end
            rad_log[k] = rd_rad;
            if (k == inj) begin frame_start = ifs; clr_overrun = iclr; end
        end
    endtask

    task automatic test_reset;
        Reset_n = 1'b0; frame_start = 1'b0; clr_overrun = 1'b0; relative_shift_z = 32'd0;
        rd_idx = '0; mem_rd_data = 32'd0;
        repeat (3) @(posedge Clk); #1;
        tests++; if ({busy, done, overrun, mem_rd_en} !== 4'b0) begin fails++; $display("FAIL reset_flags: got %b want 0000", {busy, done, overrun, mem_rd_en}); end
        tests++; if ({rd_rad, rd_x, rd_y, rd_z, rd_size} !== 160'd0) begin fails++; $display("FAIL reset_rd: got %h want 0", {rd_rad, rd_x, rd_y, rd_z, rd_size}); end
        @(negedge Clk); Reset_n = 1'b1;
        @(posedge Clk); #1;
    endtask

    task automatic test_scan;
        load_ram(32'h4000_0000, 32'h3FC0_0000, 32'hBF00_0000, 32'h4040_0000,
                 32'h3F80_0000, 32'h4040_0000, 32'hC000_0000, 32'h4120_0000);
        rd_idx = 1'b0;
        run_frame(-1, 1'b0, 1'b0);
        tests++; if (done_at !== 25) begin fails++; $display("FAIL scan_done_at: got %0d want 25", done_at); end
        tests++; if (ndone !== 1) begin fails++; $display("FAIL scan_done_count: got %0d want 1", ndone); end
        tests++; if (n_addr !== 8) begin fails++; $display("FAIL scan_addr_count: got %0d want 8", n_addr); end
        for (int i = 0; i < 8; i++) begin
            tests++; if (addr_log[i] !== 3'(i)) begin fails++; $display("FAIL scan_addr[%0d]: got %0d want %0d", i, addr_log[i], i); end
        end
        tests++; if (rd_rad !== 32'd20) begin fails++; $display("FAIL scan_rad0: got %h want %h", rd_rad, 32'd20); end
        tests++; if (rd_x !== 32'd150) begin fails++; $display("FAIL scan_x0: got %h want %h", rd_x, 32'd150); end
        tests++; if (rd_y !== 32'hFFFF_FFCE) begin fails++; $display("FAIL scan_y0: got %h want FFFFFFCE", rd_y); end
        tests++; if (rd_z !== 32'd6) begin fails++; $display("FAIL scan_z0: got %h want %h", rd_z, 32'd6); end
        rd_idx = 1'b1; #1;
        tests++; if ({rd_rad, rd_x, rd_y, rd_z} !== {32'd10, 32'd300, 32'hFFFF_FF38, 32'd20}) begin fails++; $display("FAIL scan_ball1: got %h want %h", {rd_rad, rd_x, rd_y, rd_z}, {32'd10, 32'd300, 32'hFFFF_FF38, 32'd20}); end
        tests++; if ({busy, overrun} !== 2'b00) begin fails++; $display("FAIL scan_idle: got %b want 00", {busy, overrun}); end
    endtask

    task automatic test_double_buffer;
        int stale_bad;
        load_ram(32'h3F80_0000, 32'h3E80_0000, 32'h4020_0000, 32'hBF80_0000,
                 32'h0000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000);
        rd_idx = 1'b0; #1;
        run_frame(-1, 1'b0, 1'b0);
        stale_bad = 0;
        for (int k = 0; k <= 24; k++) if (rad_log[k] !== 32'd20) stale_bad++;
        tests++; if (done_at !== 25) begin fails++; $display("FAIL dbuf_done_at: got %0d want 25", done_at); end
        tests++; if (stale_bad !== 0) begin fails++; $display("FAIL dbuf_old_held: got %0d changed cycles want 0", stale_bad); end
        tests++; if (rad_log[25] !== 32'd10) begin fails++; $display("FAIL dbuf_switch: got %h want %h", rad_log[25], 32'd10); end
        tests++; if ({rd_x, rd_y, rd_z} !== {32'd25, 32'd250, 32'hFFFF_FFFE}) begin fails++; $display("FAIL dbuf_ball0: got %h want %h", {rd_x, rd_y, rd_z}, {32'd25, 32'd250, 32'hFFFF_FFFE}); end
    endtask

    task automatic test_zero_radius;
        rd_idx = 1'b1; #1;
        tests++; if (rd_rad !== 32'd0) begin fails++; $display("FAIL zero_rad: got %h want 0", rd_rad); end
        tests++; if ({rd_x, rd_y, rd_z} !== {32'd100, 32'd200, 32'd1}) begin fails++; $display("FAIL zero_ball1: got %h want %h", {rd_x, rd_y, rd_z}, {32'd100, 32'd200, 32'd1}); end
        tests++; if (rd_size !== 32'd0) begin fails++; $display("FAIL zero_size: got %h want 0", rd_size); end
    endtask

    task automatic test_overrun;
        rd_idx = 1'b0;
        run_frame(10, 1'b1, 1'b0);
        tests++; if (done_at !== 25 || ndone !== 1) begin fails++; $display("FAIL ovr_done: got at %0d count %0d want 25/1", done_at, ndone); end
        tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_set: got %b want 1", overrun); end
        @(negedge Clk); clr_overrun = 1'b1;
        @(posedge Clk); #1 clr_overrun = 1'b0;
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_clear: got %b want 0", overrun); end
        run_frame(5, 1'b1, 1'b1);
        tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_set_wins: got %b want 1", overrun); end
        @(negedge Clk); clr_overrun = 1'b1;
        @(posedge Clk); #1 clr_overrun = 1'b0;
        run_frame(24, 1'b1, 1'b0);
        tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_commit_cycle: got %b want 1", overrun); end
        tests++; if (busy !== 1'b0 || ndone !== 1) begin fails++; $display("FAIL ovr_no_restart: got busy %b count %0d want 0/1", busy, ndone); end
    endtask

    task automatic test_preclamp;
        load_ram(32'h4000_0000, 32'h3FC0_0000, 32'hBF00_0000, 32'h4040_0000,
                 32'h3F80_0000, 32'h4040_0000, 32'hC000_0000, 32'h4120_0000);
        rd_idx = 1'b0;
`ifdef BALL_PARAM_PRECLAMP_EN
        relative_shift_z = 32'd0;
        run_frame(-1, 1'b0, 1'b0);
        tests++; if (rd_size !== 32'd36) begin fails++; $display("FAIL size_mid: got %0d want 36", rd_size); end
        relative_shift_z = -32'sd100;
        run_frame(-1, 1'b0, 1'b0);
        tests++; if (rd_size !== 32'd1) begin fails++; $display("FAIL size_low: got %0d want 1", rd_size); end
        relative_shift_z = 32'd60;
        run_frame(-1, 1'b0, 1'b0);
        tests++; if (rd_size !== 32'd80) begin fails++; $display("FAIL size_high: got %0d want 80", rd_size); end
        relative_shift_z = 32'd0;
`else
        relative_shift_z = 32'd60;
        run_frame(-1, 1'b0, 1'b0);
        tests++; if (rd_size !== 32'd0) begin fails++; $display("FAIL size_disabled: got %0d want 0", rd_size); end
        relative_shift_z = 32'd0;
`endif
    endtask

    task automatic test_reset_mid_scan;
        int seen_done, seen_busy;
        @(negedge Clk); frame_start = 1'b1;
        @(posedge Clk); #1 frame_start = 1'b0;
        repeat (3) @(posedge Clk);
        #1 frame_start = 1'b1;
        @(posedge Clk); #1 frame_start = 1'b0;
        tests++; if ({busy, overrun} !== 2'b11) begin fails++; $display("FAIL midrst_pre: got %b want 11", {busy, overrun}); end
        repeat (2) @(posedge Clk);
        @(negedge Clk); Reset_n = 1'b0; #1;
        tests++; if ({busy, done, overrun, mem_rd_en} !== 4'b0) begin fails++; $display("FAIL midrst_flags: got %b want 0000", {busy, done, overrun, mem_rd_en}); end
        tests++; if ({rd_rad, rd_x, rd_y, rd_z, rd_size} !== 160'd0) begin fails++; $display("FAIL midrst_rd: got %h want 0", {rd_rad, rd_x, rd_y, rd_z, rd_size}); end
        @(negedge Clk); Reset_n = 1'b1;
        seen_done = 0; seen_busy = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge Clk); #1;
            if (done) seen_done++;
            if (busy) seen_busy++;
        end
        tests++; if (seen_done !== 0 || seen_busy !== 0) begin fails++; $display("FAIL midrst_after: got done %0d busy %0d want 0/0", seen_done, seen_busy); end
    endtask

    initial begin
        tests = 0; fails = 0;
        test_reset;
        test_scan;
        test_double_buffer;
        test_zero_radius;
        test_overrun;
        test_preclamp;
        test_reset_mid_scan;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
